filter_sweep_ctrl: RTL and testbench
====================================

# filter_sweep_ctrl

Sequencer that drives a frequency-response sweep of the sine_gen → cascade_low_pass_filter datapath in hardware. For each sweep point it programs the sine generator period, holds generator and filter in reset for a settle window, runs for a period-proportional number of cycles while tracking the filter output's min/max, and emits one (period, peak-to-peak) result over a valid/ready handshake. It sits between the configuration register bank and the filter-characterisation result FIFO.

## Interface
Parameters:
- word_width, 16, filter sample width (two's-complement signed)
- period_width, 32, width of period fields; zero-extended to sine_gen's period port outside this block
- lut_depth_log2, 10, log2 of sine LUT depth; one generator cycle = period << lut_depth_log2 clocks

Ports:
- clk  in  1  system clock (250 MHz)
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins a sweep, sampled only in IDLE
- abort  in  1  level; forces return to IDLE from any state
- cfg_period_start  in  period_width  first period
- cfg_period_stop  in  period_width  last period (inclusive)
- cfg_period_step  in  period_width  period increment
- cfg_run_mult  in  8  generator cycles per point; 0 treated as 1
- cfg_settle  in  16  reset-hold cycles per point; 0 treated as 1
- gen_rst  out  1  active-low reset to sine_gen and all filters
- gen_period  out  period_width  period to sine_gen
- sample_in  in  word_width  filter output under test
- sample_valid  in  1  sample_in qualifier
- res_period  out  period_width  period of reported point
- res_pp  out  word_width+1  unsigned max − min over the run window
- res_valid  out  1  result valid
- res_ready  in  1  result accepted when res_valid && res_ready
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse at sweep completion (not on abort)

## Operation
- States: IDLE, SETTLE, RUN, REPORT, DONE.
- IDLE: gen_rst=0, gen_period holds last value. On start: latch all cfg_* into shadow registers, cur_period ← cfg_period_start, go to SETTLE.
- SETTLE: gen_period=cur_period, gen_rst=0 for exactly settle cycles; min ← +max, max ← −max (signed); then RUN.
- RUN: gen_rst=1 for exactly run_cycles = (cur_period << lut_depth_log2) × run_mult clock cycles (counter width period_width+lut_depth_log2+8, no truncation). Each cycle with sample_valid updates min/max. Samples outside RUN ignored. Then REPORT.
- REPORT: gen_rst=1 (generator free-runs), res_valid=1, res_period=cur_period, res_pp=max−min computed in word_width+1 bits; if no valid sample was seen, res_pp=0. Outputs stable until handshake. On handshake: next = cur_period + step computed in period_width+1 bits; if step==0, carry out, or next > stop → DONE; else cur_period ← next, SETTLE.
- cfg_period_start > cfg_period_stop: exactly one point at start, then DONE.
- DONE: done=1 for one cycle, gen_rst=0, → IDLE.
- abort (any non-IDLE state, highest priority): → IDLE next cycle, res_valid=0, gen_rst=0, no done, no partial result.
- start while busy ignored; cfg_* changes during a sweep have no effect.

## Timing
- Reset values: gen_rst=0, gen_period=0, res_period=0, res_pp=0, res_valid=0, busy=0, done=0, state IDLE.
- All outputs registered. start at edge t → busy=1 and gen_rst=0 with new gen_period from t+1.
- gen_rst rises exactly settle cycles after entering SETTLE; stays high exactly run_cycles cycles, then res_valid rises next cycle.
- Handshake at edge h → res_valid=0 at h+1; next SETTLE (gen_rst=0) at h+1, or done=1 at h+1 and busy=0 at h+2.
- Reset assertion mid-sweep: immediate return to reset values; no done.

## Test plan
- Single point: start=2, stop=2, step=5, mult=1, settle=4, res_ready=1, sample_in ramps −100..+300 → gen_rst low 4 cycles, high 2048 cycles, one result {2, 400}, done one cycle later.
- Sweep: start=2, stop=17, step=5 → results for periods 2,7,12,17 in order, then done; no result for 22.
- Backpressure: hold res_ready=0 for 50 cycles in REPORT → res_valid, res_period, res_pp stable all 50 cycles; gen_period unchanged; next SETTLE only after accept.
- Edge config: step=0, mult=0, settle=0 → one point, settle 1 cycle, run 1024×period cycles; sample_valid=0 throughout → res_pp=0. Also stop=0xFFFFFFFF, start=0xFFFFFFF0, step=0x20 → one point, no wrap.
- Abort: assert abort mid-RUN of second point → IDLE next cycle, gen_rst=0, res_valid=0, no done; new start then runs full sweep normally.
- Async reset: drop rst mid-REPORT with res_valid=1 → all outputs at reset values immediately, no done.

Source files
------------

// File: rtl/filter_sweep_ctrl_if.sv
// filter_sweep_ctrl_if
//   Result channel from the sweep sequencer to the characterisation FIFO.
//   One (period, peak-to-peak) pair per sweep point, valid/ready handshake;
//   a transfer happens on a clock edge where res_valid && res_ready.
//   Signals:
//     res_period  period of the reported point
//     res_pp      unsigned max - min of the filter output over the run window
//     res_valid   result valid (driven by the sequencer)
//     res_ready   result accepted (driven by the consumer)
interface filter_sweep_ctrl_if #(
  parameter int word_width   = 16,
  parameter int period_width = 32
) ();
  logic [period_width-1:0] res_period;
  logic [word_width:0]     res_pp;
  logic                    res_valid;
  logic                    res_ready;

  modport master (
    output res_period,
    output res_pp,
    output res_valid,
    input  res_ready
  );

  modport slave (
    input  res_period,
    input  res_pp,
    input  res_valid,
    output res_ready
  );
endinterface

// File: rtl/filter_sweep_ctrl.sv
// filter_sweep_ctrl
//   Sequencer for a frequency-response sweep of the sine_gen -> low-pass
//   cascade. For each period it holds the datapath in reset for a settle
//   window, releases it for (period << lut_depth_log2) * run_mult cycles while
//   tracking min/max of the filter output, then offers (period, max - min).
//   Ports:
//     clk, rst            clock, asynchronous active-low reset
//     start, abort        sweep start pulse (IDLE only), level abort
//     cfg_*               sweep configuration, captured at start
//     gen_rst, gen_period active-low datapath reset and generator period
//     sample_in/_valid    filter output under test
//     res                 result channel (master side)
//     busy, done          activity flag, one-cycle completion pulse
module filter_sweep_ctrl #(
  parameter int word_width     = 16,
  parameter int period_width   = 32,
  parameter int lut_depth_log2 = 10
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          abort,
  input  logic [period_width-1:0]       cfg_period_start,
  input  logic [period_width-1:0]       cfg_period_stop,
  input  logic [period_width-1:0]       cfg_period_step,
  input  logic [7:0]                    cfg_run_mult,
  input  logic [15:0]                   cfg_settle,
  output logic                          gen_rst,
  output logic [period_width-1:0]       gen_period,
  input  logic signed [word_width-1:0]  sample_in,
  input  logic                          sample_valid,
  filter_sweep_ctrl_if.master           res,
  output logic                          busy,
  output logic                          done
);
  // Wide enough for 255 full generator cycles at the largest period.
  localparam int cnt_width = period_width + lut_depth_log2 + 8;
  localparam logic signed [word_width-1:0] pos_max = {1'b0, {(word_width-1){1'b1}}};
  localparam logic signed [word_width-1:0] neg_max = {1'b1, {(word_width-1){1'b0}}};

  typedef enum logic [2:0] {ST_IDLE, ST_SETTLE, ST_RUN, ST_REPORT, ST_DONE} state_t;

  state_t                        state_reg, state_next;
  logic [period_width-1:0]       cur_period_reg, cur_period_next;
  logic [period_width-1:0]       stop_reg, stop_next;
  logic [period_width-1:0]       step_reg, step_next;
  logic [7:0]                    mult_reg, mult_next;
  logic [15:0]                   settle_reg, settle_next;
  logic [cnt_width-1:0]          cnt_reg, cnt_next;
  logic signed [word_width-1:0]  min_reg, min_next;
  logic signed [word_width-1:0]  max_reg, max_next;
  logic                          seen_reg, seen_next;
  logic                          gen_rst_reg, gen_rst_next;
  logic [period_width-1:0]       gen_period_reg, gen_period_next;
  logic [period_width-1:0]       res_period_reg, res_period_next;
  logic [word_width:0]           res_pp_reg, res_pp_next;
  logic                          res_valid_reg, res_valid_next;
  logic                          busy_reg, busy_next;
  logic                          done_reg, done_next;

  logic [7:0]                    cfg_mult_eff;
  logic [15:0]                   cfg_settle_eff;
  logic [period_width:0]         next_period;
  logic                          sweep_last;
  logic [cnt_width-1:0]          run_cycles;
  logic [word_width:0]           pp_diff;

  assign cfg_mult_eff   = (cfg_run_mult == 8'd0) ? 8'd1 : cfg_run_mult;
  assign cfg_settle_eff = (cfg_settle == 16'd0) ? 16'd1 : cfg_settle;

  // One extra bit so a period increment past the top of the range is caught
  // as a carry instead of wrapping to a small period.
  assign next_period = {1'b0, cur_period_reg} + {1'b0, step_reg};
  assign sweep_last  = (step_reg == '0) || next_period[period_width] ||
                       (next_period[period_width-1:0] > stop_reg);

  assign run_cycles = (cnt_width'(cur_period_reg) << lut_depth_log2) * cnt_width'(mult_reg);

  always_comb begin
    state_next      = state_reg;
    cur_period_next = cur_period_reg;
    stop_next       = stop_reg;
    step_next       = step_reg;
    mult_next       = mult_reg;
    settle_next     = settle_reg;
    cnt_next        = cnt_reg;
    min_next        = min_reg;
    max_next        = max_reg;
    seen_next       = seen_reg;
    gen_period_next = gen_period_reg;
    res_period_next = res_period_reg;
    res_pp_next     = res_pp_reg;
    pp_diff         = '0;

    case (state_reg)
      ST_IDLE: begin
        if (start && !abort) begin
          stop_next       = cfg_period_stop;
          step_next       = cfg_period_step;
          mult_next       = cfg_mult_eff;
          settle_next     = cfg_settle_eff;
          cur_period_next = cfg_period_start;
          cnt_next        = cnt_width'(cfg_settle_eff - 16'd1);
          state_next      = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        min_next  = pos_max;
        max_next  = neg_max;
        seen_next = 1'b0;
        if (cnt_reg == '0) begin
          // A zero period would give an empty window; it still gets one cycle.
          cnt_next   = (run_cycles == '0) ? '0 : run_cycles - cnt_width'(1);
          state_next = ST_RUN;
        end else begin
          cnt_next = cnt_reg - cnt_width'(1);
        end
      end
      ST_RUN: begin
        if (sample_valid) begin
          seen_next = 1'b1;
          if (sample_in < min_reg) min_next = sample_in;
          if (sample_in > max_reg) max_next = sample_in;
        end
        if (cnt_reg == '0) begin
          // Uses the post-update min/max so the last run cycle's sample counts.
          pp_diff         = {max_next[word_width-1], max_next} - {min_next[word_width-1], min_next};
          res_period_next = cur_period_reg;
          res_pp_next     = seen_next ? pp_diff : '0;
          state_next      = ST_REPORT;
        end else begin
          cnt_next = cnt_reg - cnt_width'(1);
        end
      end
      ST_REPORT: begin
        if (res.res_ready) begin
          if (sweep_last) begin
            state_next = ST_DONE;
          end else begin
            cur_period_next = next_period[period_width-1:0];
            cnt_next        = cnt_width'(settle_reg - 16'd1);
            state_next      = ST_SETTLE;
          end
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase

    if (abort && (state_reg != ST_IDLE)) state_next = ST_IDLE;

    // Outputs are registered from the next state so they line up with it.
    if (state_next == ST_SETTLE) gen_period_next = cur_period_next;
    gen_rst_next   = (state_next == ST_RUN) || (state_next == ST_REPORT);
    res_valid_next = (state_next == ST_REPORT);
    busy_next      = (state_next != ST_IDLE);
    done_next      = (state_next == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= ST_IDLE;
      cur_period_reg <= '0;
      stop_reg       <= '0;
      step_reg       <= '0;
      mult_reg       <= '0;
      settle_reg     <= '0;
      cnt_reg        <= '0;
      min_reg        <= '0;
      max_reg        <= '0;
      seen_reg       <= 1'b0;
      gen_rst_reg    <= 1'b0;
      gen_period_reg <= '0;
      res_period_reg <= '0;
      res_pp_reg     <= '0;
      res_valid_reg  <= 1'b0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cur_period_reg <= cur_period_next;
      stop_reg       <= stop_next;
      step_reg       <= step_next;
      mult_reg       <= mult_next;
      settle_reg     <= settle_next;
      cnt_reg        <= cnt_next;
      min_reg        <= min_next;
      max_reg        <= max_next;
      seen_reg       <= seen_next;
      gen_rst_reg    <= gen_rst_next;
      gen_period_reg <= gen_period_next;
      res_period_reg <= res_period_next;
      res_pp_reg     <= res_pp_next;
      res_valid_reg  <= res_valid_next;
      busy_reg       <= busy_next;
      done_reg       <= done_next;
    end
  end

  assign gen_rst        = gen_rst_reg;
  assign gen_period     = gen_period_reg;
  assign res.res_period = res_period_reg;
  assign res.res_pp     = res_pp_reg;
  assign res.res_valid  = res_valid_reg;
  assign busy           = busy_reg;
  assign done           = done_reg;
endmodule

// File: tb/tb_filter_sweep_ctrl.sv
// tb_filter_sweep_ctrl
//   Directed bench for filter_sweep_ctrl: reset values, single point, multi
//   point sweep, backpressure, degenerate configs, abort and async reset.
module tb_filter_sweep_ctrl;
  localparam int WW = 16;
  localparam int PW = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              abort;
  logic [PW-1:0]     cfg_period_start;
  logic [PW-1:0]     cfg_period_stop;
  logic [PW-1:0]     cfg_period_step;
  logic [7:0]        cfg_run_mult;
  logic [15:0]       cfg_settle;
  logic              gen_rst;
  logic [PW-1:0]     gen_period;
  logic signed [WW-1:0] sample_in;
  logic              sample_valid;
  logic              busy;
  logic              done;

  int total = 0;
  int bad   = 0;

  filter_sweep_ctrl_if #(.word_width(WW), .period_width(PW)) res_if ();

  filter_sweep_ctrl #(.word_width(WW), .period_width(PW), .lut_depth_log2(10)) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .abort            (abort),
    .cfg_period_start (cfg_period_start),
    .cfg_period_stop  (cfg_period_stop),
    .cfg_period_step  (cfg_period_step),
    .cfg_run_mult     (cfg_run_mult),
    .cfg_settle       (cfg_settle),
    .gen_rst          (gen_rst),
    .gen_period       (gen_period),
    .sample_in        (sample_in),
    .sample_valid     (sample_valid),
    .res              (res_if),
    .busy             (busy),
    .done             (done)
  );

  always #5 clk = ~clk;

  task automatic set_cfg(input logic [PW-1:0] s, input logic [PW-1:0] p,
                         input logic [PW-1:0] st, input logic [7:0] m, input logic [15:0] se);
    cfg_period_start = s;
    cfg_period_stop  = p;
    cfg_period_step  = st;
    cfg_run_mult     = m;
    cfg_settle       = se;
  endtask

  // Called at a negedge; returns at the negedge after the start edge.
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Drives samples while gen_rst is high and counts low/high negedges until
  // res_valid shows up. Ramp: base..base+span; otherwise alternates base and
  // base+span. Every 7th run sample is an invalid outlier that must be ignored,
  // and samples outside the run window are valid outliers that must be ignored.
  task automatic measure_point(input int base, input int span, input bit ramp, input bit vld,
                               output int lo, output int hi, output bit to);
    int idx;
    int v;
    lo = 0; hi = 0; to = 1'b1; idx = 0;
    for (int n = 0; n < 40000; n++) begin
      if (res_if.res_valid === 1'b1) begin
        to = 1'b0;
        break;
      end
      if (gen_rst === 1'b1) begin
        hi++;
        if (ramp) v = base + ((idx < span) ? idx : span);
        else      v = (idx % 2 == 1) ? base + span : base;
        if (idx % 7 == 3) begin
          sample_in    = 16'sh7000;
          sample_valid = 1'b0;
        end else begin
          sample_in    = 16'(v);
          sample_valid = vld;
        end
        idx++;
      end else begin
        lo++;
        sample_in    = 16'sh7FFF;
        sample_valid = 1'b1;
      end
      @(negedge clk);
    end
    sample_in    = 16'sh8000;
    sample_valid = 1'b1;
    if (!to) $display("result: period=%0d pp=%0d lo=%0d hi=%0d", res_if.res_period, res_if.res_pp, lo, hi);
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; abort = 1'b0; sample_in = '0; sample_valid = 1'b0;
    res_if.res_ready = 1'b1;
    set_cfg(0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++; if (gen_rst !== 1'b0) begin bad++; $display("FAIL reset_gen_rst: got %0b want 0", gen_rst); end
    total++; if (gen_period !== '0) begin bad++; $display("FAIL reset_gen_period: got %0h want 0", gen_period); end
    total++; if (res_if.res_period !== '0) begin bad++; $display("FAIL reset_res_period: got %0h want 0", res_if.res_period); end
    total++; if (res_if.res_pp !== '0) begin bad++; $display("FAIL reset_res_pp: got %0h want 0", res_if.res_pp); end
    total++; if (res_if.res_valid !== 1'b0) begin bad++; $display("FAIL reset_res_valid: got %0b want 0", res_if.res_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %0b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %0b want 0", done); end
  endtask

  task automatic test_single_point();
    int lo, hi; bit to;
    set_cfg(2, 2, 5, 1, 4);
    res_if.res_ready = 1'b1;
    pulse_start();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy: got %0b want 1", busy); end
    total++; if (gen_rst !== 1'b0) begin bad++; $display("FAIL single_gen_rst_low: got %0b want 0", gen_rst); end
    total++; if (gen_period !== 32'd2) begin bad++; $display("FAIL single_gen_period: got %0d want 2", gen_period); end
    measure_point(-100, 400, 1'b1, 1'b1, lo, hi, to);
    total++; if (to !== 1'b0) begin bad++; $display("FAIL single_timeout: got %0b want 0", to); end
    total++; if (lo != 4) begin bad++; $display("FAIL single_settle_cycles: got %0d want 4", lo); end
    total++; if (hi != 2048) begin bad++; $display("FAIL single_run_cycles: got %0d want 2048", hi); end
    total++; if (res_if.res_period !== 32'd2) begin bad++; $display("FAIL single_res_period: got %0d want 2", res_if.res_period); end
    total++; if (res_if.res_pp !== 17'd400) begin bad++; $display("FAIL single_res_pp: got %0d want 400", res_if.res_pp); end
    @(negedge clk);
    total++; if (res_if.res_valid !== 1'b0) begin bad++; $display("FAIL single_valid_drop: got %0b want 0", res_if.res_valid); end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL single_done: got %0b want 1", done); end
    total++; if (gen_rst !== 1'b0) begin bad++; $display("FAIL single_done_gen_rst: got %0b want 0", gen_rst); end
    @(negedge clk);
    total++; if (done !== 1'b0) begin bad++; $display("FAIL single_done_pulse: got %0b want 0", done); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_idle_busy: got %0b want 0", busy); end
  endtask

  task automatic test_sweep();
    int lo, hi; bit to;
    int p, span, base;
    bit extra;
    set_cfg(2, 17, 5, 1, 2);
    res_if.res_ready = 1'b1;
    pulse_start();
    for (int k = 0; k < 4; k++) begin
      p    = 2 + 5 * k;
      span = (k == 3) ? 65535 : 37 * k + 10;
      base = (k == 3) ? -32768 : -50 * k;
      measure_point(base, span, (k != 3), 1'b1, lo, hi, to);
      total++; if (to !== 1'b0) begin bad++; $display("FAIL sweep_timeout[%0d]: got %0b want 0", k, to); end
      total++; if (lo != 2) begin bad++; $display("FAIL sweep_settle[%0d]: got %0d want 2", k, lo); end
      total++; if (hi != p * 1024) begin bad++; $display("FAIL sweep_run[%0d]: got %0d want %0d", k, hi, p * 1024); end
      total++; if (res_if.res_period !== PW'(p)) begin bad++; $display("FAIL sweep_period[%0d]: got %0d want %0d", k, res_if.res_period, p); end
      total++; if (res_if.res_pp !== 17'(span)) begin bad++; $display("FAIL sweep_pp[%0d]: got %0d want %0d", k, res_if.res_pp, span); end
      @(negedge clk);
      if (k < 3) begin
        total++; if (gen_rst !== 1'b0 || res_if.res_valid !== 1'b0) begin bad++; $display("FAIL sweep_resettle[%0d]: got gen_rst=%0b valid=%0b want 0 0", k, gen_rst, res_if.res_valid); end
        total++; if (gen_period !== PW'(p + 5)) begin bad++; $display("FAIL sweep_next_period[%0d]: got %0d want %0d", k, gen_period, p + 5); end
      end else begin
        total++; if (done !== 1'b1) begin bad++; $display("FAIL sweep_done: got %0b want 1", done); end
      end
    end
    extra = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (res_if.res_valid !== 1'b0 || busy !== 1'b0) extra = 1'b1;
    end
    total++; if (extra) begin bad++; $display("FAIL sweep_no_extra_point: got activity after done want none"); end
  endtask

  task automatic test_backpressure();
    int lo, hi; bit to;
    bit stable;
    set_cfg(1, 2, 1, 1, 3);
    res_if.res_ready = 1'b0;
    pulse_start();
    measure_point(10, 100, 1'b1, 1'b1, lo, hi, to);
    total++; if (to !== 1'b0) begin bad++; $display("FAIL bp_timeout: got %0b want 0", to); end
    stable = 1'b1;
    repeat (50) begin
      if (res_if.res_valid !== 1'b1 || res_if.res_period !== 32'd1 || res_if.res_pp !== 17'd100 ||
          gen_period !== 32'd1 || gen_rst !== 1'b1) stable = 1'b0;
      @(negedge clk);
    end
    total++; if (!stable) begin bad++; $display("FAIL bp_stable: got change during stall (valid=%0b period=%0d pp=%0d) want steady", res_if.res_valid, res_if.res_period, res_if.res_pp); end
    res_if.res_ready = 1'b1;
    @(negedge clk);
    total++; if (res_if.res_valid !== 1'b0 || gen_rst !== 1'b0) begin bad++; $display("FAIL bp_accept: got valid=%0b gen_rst=%0b want 0 0", res_if.res_valid, gen_rst); end
    total++; if (gen_period !== 32'd2) begin bad++; $display("FAIL bp_next_period: got %0d want 2", gen_period); end
    measure_point(-5, 20, 1'b0, 1'b1, lo, hi, to);
    total++; if (res_if.res_pp !== 17'd20 || to) begin bad++; $display("FAIL bp_second_pp: got %0d want 20", res_if.res_pp); end
    @(negedge clk);
    total++; if (done !== 1'b1) begin bad++; $display("FAIL bp_done: got %0b want 1", done); end
    @(negedge clk);
  endtask

  task automatic test_edge_config();
    int lo, hi; bit to;
    set_cfg(1, 5, 0, 0, 0);
    res_if.res_ready = 1'b1;
    pulse_start();
    measure_point(0, 50, 1'b1, 1'b0, lo, hi, to);
    total++; if (lo != 1) begin bad++; $display("FAIL edge_settle: got %0d want 1", lo); end
    total++; if (hi != 1024) begin bad++; $display("FAIL edge_run: got %0d want 1024", hi); end
    total++; if (res_if.res_pp !== 17'd0 || to) begin bad++; $display("FAIL edge_pp_novalid: got %0d want 0", res_if.res_pp); end
    @(negedge clk);
    total++; if (done !== 1'b1) begin bad++; $display("FAIL edge_step0_done: got %0b want 1", done); end
    @(negedge clk);
    // start above stop: exactly one point
    set_cfg(2, 1, 1, 1, 1);
    pulse_start();
    measure_point(7, 3, 1'b0, 1'b1, lo, hi, to);
    total++; if (res_if.res_period !== 32'd2 || res_if.res_pp !== 17'd3 || to) begin bad++; $display("FAIL edge_above_stop: got period=%0d pp=%0d want 2 3", res_if.res_period, res_if.res_pp); end
    @(negedge clk);
    total++; if (done !== 1'b1) begin bad++; $display("FAIL edge_above_stop_done: got %0b want 1", done); end
    @(negedge clk);
    // top of range: window is far longer than the bench runs, so it must still be in RUN
    set_cfg(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 1, 1);
    pulse_start();
    total++; if (gen_period !== 32'hFFFF_FFF0) begin bad++; $display("FAIL edge_top_period: got %0h want fffffff0", gen_period); end
    repeat (100) @(negedge clk);
    total++; if (gen_rst !== 1'b1 || res_if.res_valid !== 1'b0) begin bad++; $display("FAIL edge_top_run: got gen_rst=%0b valid=%0b want 1 0", gen_rst, res_if.res_valid); end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL edge_top_abort: got busy=%0b want 0", busy); end
  endtask

  task automatic test_abort();
    int lo, hi; bit to;
    bit quiet;
    set_cfg(1, 3, 1, 1, 2);
    res_if.res_ready = 1'b1;
    pulse_start();
    measure_point(0, 10, 1'b1, 1'b1, lo, hi, to);
    @(negedge clk);
    repeat (10) @(negedge clk);
    total++; if (gen_rst !== 1'b1 || gen_period !== 32'd2) begin bad++; $display("FAIL abort_in_run: got gen_rst=%0b period=%0d want 1 2", gen_rst, gen_period); end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    total++; if (busy !== 1'b0 || gen_rst !== 1'b0 || res_if.res_valid !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL abort_idle: got busy=%0b gen_rst=%0b valid=%0b done=%0b want 0 0 0 0", busy, gen_rst, res_if.res_valid, done);
    end
    quiet = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (done !== 1'b0 || res_if.res_valid !== 1'b0) quiet = 1'b0;
    end
    total++; if (!quiet) begin bad++; $display("FAIL abort_no_done: got done/valid activity want none"); end
    // restart; a second start and new cfg while busy must be ignored
    pulse_start();
    set_cfg(9, 9, 9, 9, 9);
    pulse_start();
    for (int k = 1; k <= 3; k++) begin
      measure_point(-k, 4 * k, 1'b1, 1'b1, lo, hi, to);
      total++; if (res_if.res_period !== PW'(k) || res_if.res_pp !== 17'(4 * k) || hi != k * 1024 || to) begin
        bad++; $display("FAIL abort_rerun[%0d]: got period=%0d pp=%0d hi=%0d want %0d %0d %0d", k, res_if.res_period, res_if.res_pp, hi, k, 4 * k, k * 1024);
      end
      @(negedge clk);
    end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL abort_rerun_done: got %0b want 1", done); end
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    int lo, hi; bit to;
    bit quiet;
    set_cfg(1, 1, 1, 1, 2);
    res_if.res_ready = 1'b0;
    pulse_start();
    measure_point(3, 8, 1'b1, 1'b1, lo, hi, to);
    total++; if (res_if.res_valid !== 1'b1) begin bad++; $display("FAIL arst_pre_valid: got %0b want 1", res_if.res_valid); end
    #1 rst = 1'b0;
    #1;
    total++; if (gen_rst !== 1'b0 || gen_period !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL arst_ctrl: got gen_rst=%0b period=%0d busy=%0b done=%0b want all 0", gen_rst, gen_period, busy, done);
    end
    total++; if (res_if.res_valid !== 1'b0 || res_if.res_period !== '0 || res_if.res_pp !== '0) begin
      bad++; $display("FAIL arst_result: got valid=%0b period=%0d pp=%0d want all 0", res_if.res_valid, res_if.res_period, res_if.res_pp);
    end
    res_if.res_ready = 1'b1;
    quiet = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
    end
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
    end
    total++; if (!quiet) begin bad++; $display("FAIL arst_no_done: got activity after reset want none"); end
  endtask

  initial begin
    test_reset();
    test_single_point();
    test_sweep();
    test_backpressure();
    test_edge_config();
    test_abort();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
